// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) to one-slave memory arbiter.
// One transaction at a time, alternating under contention, with lock holding off fetches.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  input  logic        lock,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_io
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   last_data;
  logic   next_last_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_data <= 1'b0;
    end else begin
      state     <= next_state;
      last_data <= next_last_data;
    end
  end

  // Data wins unless the instruction side is owed a turn and no lock is held.
  always_comb begin
    next_state     = state;
    next_last_data = last_data;
    case (state)
      IDLE: begin
        if (data_m_access && (!instr_m_access || lock || !last_data))
          next_state = GRANT_DATA;
        else if (instr_m_access && !lock)
          next_state = GRANT_INSTR;
      end
      GRANT_INSTR: begin
        if (q_m_ack) begin
          next_state     = IDLE;
          next_last_data = 1'b0;
        end
      end
      GRANT_DATA: begin
        if (q_m_ack) begin
          next_state     = IDLE;
          next_last_data = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Slave-side mux is selected purely by the registered state.
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_io         = 1'b0;
    case (state)
      GRANT_INSTR: begin
        q_m_access  = 1'b1;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
      end
      GRANT_DATA: begin
        q_m_access   = 1'b1;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        q_io         = d_io;
      end
      default: ;
    endcase
  end

  assign instr_m_ack     = q_m_ack && (state == GRANT_INSTR);
  assign data_m_ack      = q_m_ack && (state == GRANT_DATA);
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: single-master transfers, alternation,
// lock behaviour and reset during a grant.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;
  logic        lock;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_io;

  int testCount = 0;
  int failCount = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_data_in(instr_m_data_in),
    .instr_m_access(instr_m_access), .instr_m_ack(instr_m_ack),
    .data_m_addr(data_m_addr), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .data_m_access(data_m_access),
    .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .d_io(d_io), .lock(lock),
    .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in),
    .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_io(q_io)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int expGrant [8];
    expGrant = '{2, 0, 1, 0, 2, 0, 1, 0};

    reset           = 1'b1;
    instr_m_addr    = '0;
    instr_m_access  = 1'b0;
    data_m_addr     = '0;
    data_m_data_out = '0;
    data_m_access   = 1'b0;
    data_m_wr_en    = 1'b0;
    data_m_bytesel  = 2'b00;
    d_io            = 1'b0;
    lock            = 1'b0;
    q_m_data_in     = '0;
    q_m_ack         = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_access", q_m_access, 0);
    checkOutput("rst_wr_en", q_m_wr_en, 0);
    checkOutput("rst_io", q_io, 0);
    checkOutput("rst_addr", q_m_addr, 0);
    checkOutput("rst_dout", q_m_data_out, 0);
    checkOutput("rst_bytesel", q_m_bytesel, 0);
    checkOutput("rst_iack", instr_m_ack, 0);
    checkOutput("rst_dack", data_m_ack, 0);
    reset = 1'b0;

    // Instruction-only fetch, slave acks two cycles after the grant.
    instr_m_addr   = 19'h0_8000;
    instr_m_access = 1'b1;
    #1;
    checkOutput("i_no_comb_path", q_m_access, 0);
    applyStimulus();
    checkOutput("i_access", q_m_access, 1);
    checkOutput("i_addr", q_m_addr, 32'h0_8000);
    checkOutput("i_bytesel", q_m_bytesel, 2'b11);
    checkOutput("i_wr_en", q_m_wr_en, 0);
    checkOutput("i_dout", q_m_data_out, 0);
    checkOutput("i_ack_early", instr_m_ack, 0);
    applyStimulus();
    instr_m_access = 1'b0;
    applyStimulus();
    checkOutput("i_hold_after_drop", q_m_access, 1);
    q_m_ack     = 1'b1;
    q_m_data_in = 16'hBEEF;
    #1;
    checkOutput("i_ack", instr_m_ack, 1);
    checkOutput("i_rdata", instr_m_data_in, 16'hBEEF);
    checkOutput("i_dack_quiet", data_m_ack, 0);
    applyStimulus();
    q_m_ack = 1'b0;
    #1;
    checkOutput("i_idle_access", q_m_access, 0);
    checkOutput("i_idle_bytesel", q_m_bytesel, 0);
    checkOutput("i_idle_iack", instr_m_ack, 0);

    // Data write to I/O space with a zero-wait slave.
    data_m_addr     = 19'h0_1234;
    data_m_data_out = 16'hA55A;
    data_m_bytesel  = 2'b01;
    data_m_wr_en    = 1'b1;
    d_io            = 1'b1;
    data_m_access   = 1'b1;
    applyStimulus();
    checkOutput("d_access", q_m_access, 1);
    checkOutput("d_addr", q_m_addr, 32'h0_1234);
    checkOutput("d_dout", q_m_data_out, 16'hA55A);
    checkOutput("d_bytesel", q_m_bytesel, 2'b01);
    checkOutput("d_wr_en", q_m_wr_en, 1);
    checkOutput("d_io", q_io, 1);
    q_m_ack = 1'b1;
    #1;
    checkOutput("d_ack", data_m_ack, 1);
    checkOutput("d_iack_quiet", instr_m_ack, 0);
    applyStimulus();
    data_m_access = 1'b0;
    q_m_ack       = 1'b0;
    #1;
    checkOutput("d_idle_access", q_m_access, 0);
    checkOutput("d_idle_addr", q_m_addr, 0);
    checkOutput("d_idle_wr_en", q_m_wr_en, 0);
    checkOutput("d_idle_io", q_io, 0);

    // Both masters requesting continuously from reset: D, idle, I, idle, ...
    reset          = 1'b1;
    instr_m_access = 1'b1;
    data_m_access  = 1'b1;
    applyStimulus();
    checkOutput("alt_rst_access", q_m_access, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      q_m_ack = 1'b0;
      #1;
      checkOutput($sformatf("alt_access_%0d", i), q_m_access, (expGrant[i] != 0) ? 1 : 0);
      checkOutput($sformatf("alt_wr_en_%0d", i), q_m_wr_en, (expGrant[i] == 2) ? 1 : 0);
      if (expGrant[i] != 0) q_m_ack = 1'b1;
      #1;
      checkOutput($sformatf("alt_dack_%0d", i), data_m_ack, (expGrant[i] == 2) ? 1 : 0);
      checkOutput($sformatf("alt_iack_%0d", i), instr_m_ack, (expGrant[i] == 1) ? 1 : 0);
    end
    q_m_ack = 1'b0;

    // Lock held across two data transactions while a fetch is pending.
    reset = 1'b1;
    lock  = 1'b1;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("lk_grant1_wr", q_m_wr_en, 1);
    checkOutput("lk_grant1_addr", q_m_addr, 32'h0_1234);
    q_m_ack = 1'b1;
    #1;
    checkOutput("lk_dack1", data_m_ack, 1);
    applyStimulus();
    q_m_ack = 1'b0;
    #1;
    checkOutput("lk_idle1", q_m_access, 0);
    applyStimulus();
    checkOutput("lk_grant2_addr", q_m_addr, 32'h0_1234);
    checkOutput("lk_grant2_wr", q_m_wr_en, 1);
    q_m_ack       = 1'b1;
    lock          = 1'b0;
    data_m_access = 1'b0;
    #1;
    checkOutput("lk_dack2", data_m_ack, 1);
    applyStimulus();
    q_m_ack = 1'b0;
    #1;
    checkOutput("lk_idle2", q_m_access, 0);
    applyStimulus();
    checkOutput("lk_igrant_access", q_m_access, 1);
    checkOutput("lk_igrant_addr", q_m_addr, 32'h0_8000);
    checkOutput("lk_igrant_bytesel", q_m_bytesel, 2'b11);
    q_m_ack = 1'b1;
    #1;
    checkOutput("lk_iack", instr_m_ack, 1);
    applyStimulus();
    q_m_ack        = 1'b0;
    instr_m_access = 1'b0;

    // Complete one data transfer, then reset during a second data grant.
    data_m_access = 1'b1;
    applyStimulus();
    q_m_ack = 1'b1;
    #1;
    checkOutput("rs_dack_pre", data_m_ack, 1);
    applyStimulus();
    q_m_ack = 1'b0;
    applyStimulus();
    checkOutput("rs_grant", q_m_access, 1);
    checkOutput("rs_grant_wr", q_m_wr_en, 1);
    reset = 1'b1;
    applyStimulus();
    checkOutput("rs_abort_access", q_m_access, 0);
    reset          = 1'b0;
    q_m_ack        = 1'b1;
    instr_m_access = 1'b1;
    #1;
    checkOutput("rs_late_dack", data_m_ack, 0);
    checkOutput("rs_late_iack", instr_m_ack, 0);
    applyStimulus();
    q_m_ack = 1'b0;
    #1;
    checkOutput("rs_first_access", q_m_access, 1);
    checkOutput("rs_first_is_data", q_m_wr_en, 1);
    checkOutput("rs_first_addr", q_m_addr, 32'h0_1234);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter between the core's instruction bus (prefetch) and data bus (load/store, I/O) and the single external memory/I/O port. It grants one transaction at a time, forwards address/data/control of the granted master, and routes the slave ack back to that master only. Arbitration alternates under contention. Locked data sequences (`lock`) hold off instruction fetches.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_m_addr` in [19:1]: instruction fetch word address.
- `instr_m_data_in` out 16: fetch read data, equal to `q_m_data_in`.
- `instr_m_access` in 1: fetch request, held until ack.
- `instr_m_ack` out 1: fetch complete; `q_m_ack` gated by instruction grant.
- `data_m_addr` in [19:1]: data word address.
- `data_m_data_in` out 16: data read data, equal to `q_m_data_in`.
- `data_m_data_out` in 16: data write data.
- `data_m_access` in 1: data request, held until ack.
- `data_m_ack` out 1: data complete; `q_m_ack` gated by data grant.
- `data_m_wr_en` in 1: 1 for write.
- `data_m_bytesel` in 2: byte lanes, bit0 = low byte.
- `d_io` in 1: data request targets I/O space.
- `lock` in 1: data master holds a locked sequence.
- `q_m_addr` out [19:1]: slave address.
- `q_m_data_in` in 16: slave read data.
- `q_m_data_out` out 16: slave write data.
- `q_m_access` out 1: slave request.
- `q_m_ack` in 1: slave completion, one cycle per transaction.
- `q_m_wr_en` out 1: slave write strobe.
- `q_m_bytesel` out 2: slave byte lanes.
- `q_io` out 1: slave I/O cycle.

## Operation
- States: IDLE, GRANT_INSTR, GRANT_DATA. There is also a 1-bit `last_data` register that records the master served most recently.
- Transitions out of IDLE:
  - Only `data_m_access` asserted → GRANT_DATA.
  - Only `instr_m_access` asserted and `lock` low → GRANT_INSTR.
  - Both asserted and `lock` high → GRANT_DATA.
  - Both asserted and `lock` low → serve the master not served last. If `last_data`=1, go to GRANT_INSTR; otherwise go to GRANT_DATA.
  - `instr_m_access` asserted with `lock` high and no data request → stay in IDLE. No instruction fetch may start while `lock` is high.
- Behaviour in a GRANT state:
  - `q_m_access`=1.
  - Slave outputs are muxed combinationally from the granted master.
  - On `q_m_ack`=1, return to IDLE and set `last_data` to 1 if the state was GRANT_DATA, else 0.
- Behaviour in IDLE:
  - `q_m_access`, `q_m_wr_en` and `q_io` are 0.
  - `q_m_addr`, `q_m_data_out` and `q_m_bytesel` are 0.
- Instruction grant drives:
  - `q_m_wr_en`=0, `q_io`=0, `q_m_bytesel`=2'b11.
  - `q_m_data_out`=0, `q_m_addr`=`instr_m_addr`.
- Data grant drives all data-side signals through unchanged.
- Acks:
  - `instr_m_ack`=`q_m_ack` & GRANT_INSTR.
  - `data_m_ack`=`q_m_ack` & GRANT_DATA.
  - `q_m_ack` arriving in IDLE is ignored.
- Read data goes to both masters unconditionally; only the acked master samples it.
- If the granted master drops access before the ack (a protocol violation), the state is unchanged until `q_m_ack`.
- Reset, including mid-transaction: state goes to IDLE and `last_data` goes to 0. The slave sees `q_m_access`=0 on the cycle after the reset edge. An ack for the aborted transaction is ignored.

## Timing
- Request first seen high in cycle N while IDLE → `q_m_access` high in N+1.
- Ack in cycle M is forwarded to the master combinationally in M. The state is IDLE in M+1, and the next grant is driven in M+2.
- Minimum turnaround between back-to-back transactions is one idle cycle.
- A zero-wait slave (ack in the first granted cycle) gives 2 cycles per transaction.
- Grant and mux select come from registers only, so there is no combinational path from `*_m_access` to `q_m_*`.
- The ack gating path, `q_m_ack` → `*_m_ack`, is combinational.
- Reset values:
  - `q_m_access`, `q_m_wr_en`, `q_io`, `instr_m_ack`, `data_m_ack` = 0.
  - `q_m_addr`, `q_m_data_out`, `q_m_bytesel` = 0.

## Test plan
- Instruction only: `instr_m_addr`=19'h0_8000, slave acks 2 cycles after grant with 16'hBEEF → `q_m_access` rises 1 cycle after the request. `q_m_bytesel`=11, `q_m_wr_en`=0. `instr_m_ack` pulses once with data BEEF, and `data_m_ack` stays 0.
- Data write: addr 19'h1234, data 16'hA55A, bytesel 01, `d_io`=1 → slave sees the same values with `q_m_wr_en`=1 and `q_io`=1. `data_m_ack` pulses on the slave ack.
- Simultaneous requests held continuously from reset → grant order is data, instr, data, instr, with exactly one idle cycle between grants.
- `lock`=1 across two data transactions while the instruction request stays pending → both data grants complete before any instruction grant. The instruction grant occurs 2 cycles after `lock` falls, with the state IDLE.
- Reset asserted during GRANT_DATA before any ack → `q_m_access`=0 on the next cycle. A late `q_m_ack` produces no `*_m_ack`. With both masters then requesting, the first grant goes to data.
